// File: rtl/vga_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and default 640x480@60 timing for the raster-scan driver.
//   rgb_t     : 4:4:4 pixel colour
//   coord_t   : raw scan coordinate (totals up to 1024)
//   timing_t  : {hsync active, vsync active, display enable} bundle carried
//               through the alignment delay line
//   total4()  : sums the four segments of one timing axis
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef logic [11:0] rgb_t;
    typedef logic [9:0]  coord_t;

    // Sync flags are stored active-high so a cleared delay stage means
    // "not in sync" and the outputs stay deasserted right after reset.
    typedef struct packed {
        logic hs_act;
        logic vs_act;
        logic de;
    } timing_t;

    localparam int   DEF_H_VISIBLE  = 640;
    localparam int   DEF_H_FP       = 16;
    localparam int   DEF_H_SYNC     = 96;
    localparam int   DEF_H_BP       = 48;
    localparam int   DEF_V_VISIBLE  = 480;
    localparam int   DEF_V_FP       = 10;
    localparam int   DEF_V_SYNC     = 2;
    localparam int   DEF_V_BP       = 33;
    localparam int   DEF_PIPE       = 1;
    localparam int   DEF_START_LINE = 480;
    localparam rgb_t DEF_FG_RGB     = 12'hFFF;
    localparam rgb_t DEF_BG_RGB     = 12'h000;

    function automatic int total4(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/vga_scan_driver_if.sv
// -----------------------------------------------------------------------------
// vga_scan_driver_if
// Bundle between the scan driver and its renderer / video sink.
//   pix_en    : pixel-rate enable (into driver)
//   white     : renderer pixel response (into driver)
//   x, y      : raw scan coordinates (from driver)
//   start_t   : one-clk renderer recompute pulse (from driver)
//   hsync, vsync (active-low), de, rgb, frame_cnt : aligned video (from driver)
// master = scan driver, slave = renderer/sink side.
// -----------------------------------------------------------------------------
interface vga_scan_driver_if;
    import vga_pkg::*;

    logic       pix_en;
    logic       white;
    coord_t     x;
    coord_t     y;
    logic       start_t;
    logic       hsync;
    logic       vsync;
    logic       de;
    rgb_t       rgb;
    logic [7:0] frame_cnt;

    modport master (
        input  pix_en, white,
        output x, y, start_t, hsync, vsync, de, rgb, frame_cnt
    );

    modport slave (
        output pix_en, white,
        input  x, y, start_t, hsync, vsync, de, rgb, frame_cnt
    );

endinterface

// File: rtl/vga_scan_driver_sync_delay.sv
// -----------------------------------------------------------------------------
// sync_delay
// Generic DEPTH-stage shift register, cleared asynchronously to zero.
//   clk  : clock            rst : async reset, active-high
//   i_d  : data in          o_q : data in delayed by DEPTH clocks
// Shifts every clock; DEPTH must be at least 1.
// -----------------------------------------------------------------------------
module sync_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // NOTE: the stages are cleared in reset because stale sync/enable bits
    // would otherwise reach the outputs for PIPE clocks after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_driver.sv
// -----------------------------------------------------------------------------
// vga_scan_driver
// Raster-scan master for the vector renderers: produces raw x/y, a per-frame
// start_t pulse, samples the renderer's white response PIPE clocks later and
// emits aligned hsync/vsync/de/rgb plus a frame counter.
//   clk : system clock
//   rst : asynchronous reset, active-high
//   bus : vga_scan_driver_if.master (pix_en, white in; scan/video out)
// -----------------------------------------------------------------------------
module vga_scan_driver
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE  = DEF_H_VISIBLE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_VISIBLE  = DEF_V_VISIBLE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter int   PIPE       = DEF_PIPE,
    parameter int   START_LINE = DEF_START_LINE,
    parameter rgb_t FG_RGB     = DEF_FG_RGB,
    parameter rgb_t BG_RGB     = DEF_BG_RGB
) (
    input  logic              clk,
    input  logic              rst,
    vga_scan_driver_if.master bus
);

    localparam int H_TOTAL = total4(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total4(V_VISIBLE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t START_PREV = coord_t'(START_LINE - 1);
    localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
    localparam coord_t HS_BEG     = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_BEG     = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    coord_t     r_x;
    coord_t     r_y;
    logic [7:0] r_frame_cnt;
    logic       r_start_t;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_de;
    rgb_t       r_rgb;

    logic       w_line_end;
    logic       w_frame_end;
    logic       w_to_start;
    timing_t    w_raw;
    timing_t    w_dly;

    assign w_line_end  = bus.pix_en && (r_x == H_LAST);
    assign w_frame_end = w_line_end && (r_y == V_LAST);
    // Fires only on the advancing edge into (0, START_LINE), so a pix_en
    // stall parked on that coordinate cannot re-trigger it.
    assign w_to_start  = w_line_end && (r_y == START_PREV);

    // NOTE: state registers use non-blocking assignments so every register
    // in the block updates from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= '0;
            r_start_t   <= 1'b0;
        end else begin
            r_start_t <= w_to_start;
            if (bus.pix_en) begin
                if (w_line_end) begin
                    r_x <= '0;
                    r_y <= w_frame_end ? '0 : r_y + 10'd1;
                end else begin
                    r_x <= r_x + 10'd1;
                end
                if (w_frame_end) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    // NOTE: every field is assigned on every evaluation, so no latch forms.
    always_comb begin
        w_raw.de     = (r_x < H_VIS_END) && (r_y < V_VIS_END);
        w_raw.hs_act = (r_x >= HS_BEG) && (r_x < HS_END);
        w_raw.vs_act = (r_y >= VS_BEG) && (r_y < VS_END);
    end

    // The delay line matches the renderer latency; it shifts every clock
    // because the renderer sees x/y held steady across pix_en gaps.
    generate
        if (PIPE == 0) begin : g_bypass
            assign w_dly = w_raw;
        end else begin : g_delay
            sync_delay #(
                .WIDTH ($bits(timing_t)),
                .DEPTH (PIPE)
            ) u_sync_delay (
                .clk (clk),
                .rst (rst),
                .i_d (w_raw),
                .o_q (w_dly)
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_de    <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_hsync <= ~w_dly.hs_act;
            r_vsync <= ~w_dly.vs_act;
            r_de    <= w_dly.de;
            r_rgb   <= w_dly.de ? (bus.white ? FG_RGB : BG_RGB) : '0;
        end
    end

    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.start_t   = r_start_t;
    assign bus.hsync     = r_hsync;
    assign bus.vsync     = r_vsync;
    assign bus.de        = r_de;
    assign bus.rgb       = r_rgb;

endmodule
